// File: rtl/cipher_mm_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cipher_mm_ctrl: bus-mapped start/done/watchdog controller for a cipher core |
// | Revision: 1.0                                                               |
// +--------------------------------------------------------------------------+
module cipher_mm_ctrl #(
    parameter int DATA_W  = 32,
    parameter int BLOCK_W = 64,
    parameter int KEY_W   = 80,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               iReset,
    input  logic               iChipselect_n,
    input  logic               iWrite_n,
    input  logic               iRead_n,
    input  logic [4:0]         iAddress,
    input  logic [DATA_W-1:0]  idat,
    output logic [DATA_W-1:0]  odat,
    output logic               oIrq,
    output logic               oCoreReset_n,
    output logic               oCoreLoad,
    output logic               oCoreMode,
    output logic [KEY_W-1:0]   oCoreKey,
    output logic [BLOCK_W-1:0] oCoreData,
    input  logic               iCoreDone,
    input  logic [BLOCK_W-1:0] iCoreData
);

    localparam int KW = (KEY_W + DATA_W - 1) / DATA_W;
    localparam int BW = (BLOCK_W + DATA_W - 1) / DATA_W;
    localparam int PW = 8 * DATA_W;
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_ABORT} state_t;

    state_t              state_q;
    logic [KEY_W-1:0]    key_q, key_d;
    logic [BLOCK_W-1:0]  din_q, din_d, dout_q;
    logic [DATA_W-1:0]   odat_q, rdata_d;
    logic [CW-1:0]       cnt_q;
    logic                mode_q, irq_en_q, done_q, err_q, load_q, core_rst_n_q;

    logic                wr_en, rd_en, busy, prot_wr;
    logic                sel_ctrl, sel_stat, sel_key, sel_din, sel_dout;
    logic [2:0]          idx;
    logic [31:0]         off;
    logic [PW-1:0]       key_pad, din_pad, dout_pad, key_wr, din_wr;

    always_comb begin
        wr_en    = !iChipselect_n && !iWrite_n;
        rd_en    = !iChipselect_n && iWrite_n && !iRead_n;
        busy     = (state_q != S_IDLE);
        idx      = iAddress[2:0];
        off      = 32'(idx) * DATA_W;
        sel_ctrl = (iAddress == 5'h00);
        sel_stat = (iAddress == 5'h01);
        sel_key  = (iAddress[4:3] == 2'b01) && (32'(idx) < KW);
        sel_din  = (iAddress[4:3] == 2'b10) && (32'(idx) < BW);
        sel_dout = (iAddress[4:3] == 2'b11) && (32'(idx) < BW);
        prot_wr  = wr_en && busy && (sel_ctrl || sel_key || sel_din);

        // Zero-padded views: bits past KEY_W/BLOCK_W drop on write and read as 0
        key_pad  = '0;
        din_pad  = '0;
        dout_pad = '0;
        key_pad[KEY_W-1:0]    = key_q;
        din_pad[BLOCK_W-1:0]  = din_q;
        dout_pad[BLOCK_W-1:0] = dout_q;
        key_wr = key_pad;
        din_wr = din_pad;
        key_wr[off +: DATA_W] = idat;
        din_wr[off +: DATA_W] = idat;
        key_d = key_wr[KEY_W-1:0];
        din_d = din_wr[BLOCK_W-1:0];

        rdata_d = '0;
        if (sel_ctrl)      rdata_d[2:0] = {irq_en_q, mode_q, 1'b0};
        else if (sel_stat) rdata_d[2:0] = {err_q, done_q, busy};
        else if (sel_key)  rdata_d = key_pad[off +: DATA_W];
        else if (sel_din)  rdata_d = din_pad[off +: DATA_W];
        else if (sel_dout) rdata_d = dout_pad[off +: DATA_W];
    end

    always_ff @(posedge clk or posedge iReset) begin
        if (iReset) begin
            state_q      <= S_IDLE;
            key_q        <= '0;
            din_q        <= '0;
            dout_q       <= '0;
            odat_q       <= '0;
            cnt_q        <= '0;
            mode_q       <= 1'b0;
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            load_q       <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            load_q       <= 1'b0;
            core_rst_n_q <= 1'b1;

            if (wr_en)      odat_q <= '0;
            else if (rd_en) odat_q <= rdata_d;

            if (wr_en && !busy) begin
                if (sel_key) key_q <= key_d;
                if (sel_din) din_q <= din_d;
                if (sel_ctrl) begin
                    mode_q   <= idat[1];
                    irq_en_q <= idat[2];
                end
            end

            // Clears come first so any set later in this block takes priority
            if (wr_en && sel_stat) begin
                if (idat[1]) done_q <= 1'b0;
                if (idat[2]) err_q  <= 1'b0;
            end
            if (prot_wr) err_q <= 1'b1;

            unique case (state_q)
                S_IDLE: begin
                    if (wr_en && sel_ctrl && idat[0]) begin
                        done_q  <= 1'b0;
                        load_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    cnt_q   <= '0;
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    if (iCoreDone) begin
                        dout_q  <= iCoreData;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        err_q        <= 1'b1;
                        core_rst_n_q <= 1'b0;
                        state_q      <= S_ABORT;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_ABORT: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign odat         = odat_q;
    assign oIrq         = done_q & irq_en_q;
    assign oCoreReset_n = core_rst_n_q;
    assign oCoreLoad    = load_q;
    assign oCoreMode    = mode_q;
    assign oCoreKey     = key_q;
    assign oCoreData    = din_q;

endmodule
`default_nettype wire

// File: tb/tb_cipher_mm_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cipher_mm_ctrl: scoreboard bench for cipher_mm_ctrl                      |
// | Revision: 1.0                                                               |
// +--------------------------------------------------------------------------+
module tb_cipher_mm_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        csa_n, csb_n, wr_n, rd_n;
    logic [4:0]  addr;
    logic [31:0] wdat;

    logic [31:0] odat_a, odat_b;
    logic        irq_a, irq_b, crst_a, crst_b, load_a, load_b, mode_a, mode_b;
    logic [79:0] key_a, key_b;
    logic [63:0] data_a, data_b;

    int cyc_cnt = 0;
    int n_chk = 0;
    int n_fail = 0;
    int n_loads = 0;
    int ccnt_a, ccnt_b;
    int lat_a = 33;
    int lat_b = 0;

    wire cdone_a = (lat_a != 0) && (ccnt_a == lat_a);
    wire cdone_b = (lat_b != 0) && (ccnt_b == lat_b);

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
    always @(negedge clk) if (load_a) n_loads++;

    // Behavioural cores: count cycles from the load pulse, assert done at lat
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ccnt_a <= 0;
            ccnt_b <= 0;
        end else begin
            if (load_a) ccnt_a <= 1;
            else if (ccnt_a != 0 && ccnt_a < 1000) ccnt_a <= ccnt_a + 1;
            if (load_b) ccnt_b <= 1;
            else if (ccnt_b != 0 && ccnt_b < 1000) ccnt_b <= ccnt_b + 1;
        end
    end

    cipher_mm_ctrl u_dut_a (
        .clk(clk), .iReset(rst), .iChipselect_n(csa_n), .iWrite_n(wr_n), .iRead_n(rd_n),
        .iAddress(addr), .idat(wdat), .odat(odat_a), .oIrq(irq_a), .oCoreReset_n(crst_a),
        .oCoreLoad(load_a), .oCoreMode(mode_a), .oCoreKey(key_a), .oCoreData(data_a),
        .iCoreDone(cdone_a), .iCoreData(64'h5579C1387B228445)
    );

    cipher_mm_ctrl #(.TIMEOUT(16)) u_dut_b (
        .clk(clk), .iReset(rst), .iChipselect_n(csb_n), .iWrite_n(wr_n), .iRead_n(rd_n),
        .iAddress(addr), .idat(wdat), .odat(odat_b), .oIrq(irq_b), .oCoreReset_n(crst_b),
        .oCoreLoad(load_b), .oCoreMode(mode_b), .oCoreKey(key_b), .oCoreData(data_b),
        .iCoreDone(cdone_b), .iCoreData(64'h0123456789ABCDEF)
    );

    typedef struct {
        string       name;
        bit          sel;
        logic [31:0] exp;
    } exp_t;
    exp_t sbq[$];

    bit   mon_v, mon_sel;
    exp_t mon_e;
    logic [31:0] mon_act;

    always @(posedge clk) begin
        mon_v   <= (!csa_n || !csb_n) && wr_n && !rd_n;
        mon_sel <= !csb_n;
    end

    always @(negedge clk) begin
        if (mon_v) begin
            n_chk++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_read: odat observed with no expectation queued");
            end else begin
                mon_e   = sbq.pop_front();
                mon_act = mon_sel ? odat_b : odat_a;
                if (mon_act !== mon_e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", mon_e.name, mon_act, mon_e.exp);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic bus_wr(input bit b, input logic [4:0] a, input logic [31:0] d);
        if (b) csb_n = 1'b0; else csa_n = 1'b0;
        wr_n = 1'b0; addr = a; wdat = d;
        @(posedge clk); #1;
        csa_n = 1'b1; csb_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic bus_rd(input bit b, input logic [4:0] a, input logic [31:0] e, input string nm);
        sbq.push_back('{nm, b, e});
        if (b) csb_n = 1'b0; else csa_n = 1'b0;
        rd_n = 1'b0; addr = a;
        @(posedge clk); #1;
        csa_n = 1'b1; csb_n = 1'b1; rd_n = 1'b1;
    endtask

    task automatic run_encrypt(input string tag, input bit busy_wr);
        int t0, n, l0;
        l0 = n_loads;
        bus_wr(0, 5'h00, 32'h5);
        t0 = cyc_cnt;
        if (busy_wr) begin
            bus_wr(0, 5'h10, 32'hDEADBEEF);
            bus_rd(0, 5'h01, 32'h5, "status_busy_err");
            bus_rd(0, 5'h10, 32'h0, "din0_protected");
        end
        n = 0;
        while (!irq_a && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_busy_cycles"}, 128'(cyc_cnt - t0), 128'd34);
        chk({tag, "_load_pulses"}, 128'(n_loads - l0), 128'd1);
        chk({tag, "_irq_set"}, 128'(irq_a), 128'd1);
        bus_rd(0, 5'h18, 32'h7B228445, {tag, "_dout0"});
        bus_rd(0, 5'h19, 32'h5579C138, {tag, "_dout1"});
        bus_rd(0, 5'h01, busy_wr ? 32'h6 : 32'h2, {tag, "_status_done"});
        bus_rd(0, 5'h00, 32'h4, {tag, "_ctrl_rd"});
        bus_wr(0, 5'h01, 32'h6);
        chk({tag, "_irq_cleared"}, 128'(irq_a), 128'd0);
        bus_rd(0, 5'h01, 32'h0, {tag, "_status_cleared"});
    endtask

    initial begin
        int lowcnt, lowat, t0, n;
        rst = 1'b1; csa_n = 1'b1; csb_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
        addr = '0; wdat = '0;
        #2;
        chk("rst_odat", 128'(odat_a), 128'd0);
        chk("rst_irq", 128'(irq_a), 128'd0);
        chk("rst_load", 128'(load_a), 128'd0);
        chk("rst_mode", 128'(mode_a), 128'd0);
        chk("rst_key", 128'(key_a), 128'd0);
        chk("rst_data", 128'(data_a), 128'd0);
        chk("rst_core_rst_n", 128'(crst_a), 128'd0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("core_rst_n_release", 128'(crst_a), 128'd1);
        bus_rd(0, 5'h01, 32'h0, "status_rst");
        bus_rd(0, 5'h18, 32'h0, "dout0_rst");

        // Partial top key word
        bus_wr(0, 5'h0A, 32'hFFFFFFFF);
        bus_rd(0, 5'h0A, 32'h0000FFFF, "key2_partial");
        chk("core_key_top", 128'(key_a[79:64]), 128'hFFFF);
        chk("core_key_low", 128'(key_a[63:0]), 128'd0);
        bus_wr(0, 5'h0A, 32'h0);
        bus_wr(0, 5'h08, 32'h0);
        bus_wr(0, 5'h09, 32'h0);
        bus_wr(0, 5'h10, 32'h0);
        bus_wr(0, 5'h11, 32'h0);
        chk("core_key_zero", 128'(key_a), 128'd0);

        run_encrypt("enc", 1'b1);
        chk("enc_mode", 128'(mode_a), 128'd0);

        // Reset in the middle of RUN
        bus_wr(0, 5'h08, 32'h12345678);
        bus_wr(0, 5'h00, 32'h7);
        chk("mode_decrypt", 128'(mode_a), 128'd1);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_key", 128'(key_a), 128'd0);
        chk("midrst_mode", 128'(mode_a), 128'd0);
        chk("midrst_load", 128'(load_a), 128'd0);
        chk("midrst_irq", 128'(irq_a), 128'd0);
        chk("midrst_core_rst_n", 128'(crst_a), 128'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        bus_rd(0, 5'h01, 32'h0, "midrst_status");
        bus_rd(0, 5'h00, 32'h0, "midrst_ctrl");
        bus_rd(0, 5'h08, 32'h0, "midrst_key0");
        run_encrypt("rerun", 1'b0);

        // Strobe collision and unmapped reads
        bus_wr(0, 5'h08, 32'h11);
        bus_rd(0, 5'h08, 32'h11, "key0_rd");
        csa_n = 1'b0; wr_n = 1'b0; rd_n = 1'b0; addr = 5'h08; wdat = 32'h22;
        @(posedge clk); #1;
        csa_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
        chk("collision_odat", 128'(odat_a), 128'd0);
        bus_rd(0, 5'h08, 32'h22, "collision_wrote");
        bus_rd(0, 5'h03, 32'h0, "unmapped_03");
        bus_rd(0, 5'h08, 32'h22, "key0_again");
        bus_rd(0, 5'h1F, 32'h0, "unmapped_1f");

        // Watchdog on the TIMEOUT=16 instance, core never responds
        bus_wr(1, 5'h00, 32'h1);
        t0 = cyc_cnt; lowcnt = 0; lowat = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (!crst_b) begin
                lowcnt++;
                lowat = cyc_cnt - t0;
            end
        end
        chk("wd_reset_low_cycles", 128'(lowcnt), 128'd1);
        chk("wd_reset_low_when", 128'(lowat), 128'd17);
        bus_rd(1, 5'h01, 32'h4, "wd_status_err");
        bus_rd(1, 5'h18, 32'h0, "wd_dout_unchanged");
        bus_wr(1, 5'h01, 32'h4);
        bus_rd(1, 5'h01, 32'h0, "wd_err_cleared");

        // Core done arrives on the expiry edge
        lat_b = 16;
        bus_wr(1, 5'h00, 32'h1);
        lowcnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (!crst_b) lowcnt++;
        end
        chk("wd_done_no_abort", 128'(lowcnt), 128'd0);
        bus_rd(1, 5'h01, 32'h2, "wd_done_wins");
        bus_rd(1, 5'h18, 32'h89ABCDEF, "wd_dout0");

        n = 0;
        while (sbq.size() != 0 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("scoreboard_drained", 128'(sbq.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cipher_mm_ctrl.md
# cipher_mm_ctrl

Parametrised memory-mapped controller for an iterative block-cipher core such as PRESENT. It adds configurable key and block widths, a start/busy/done handshake, a status register with sticky error, an interrupt and a watchdog abort. It sits between the processor peripheral bus (active-low chip-select, write and read strobes) and one cipher core. The core is instantiated outside this block and is reached through the core-side ports.

## Interface
Parameters:
- DATA_W, 32, bus word width.
- BLOCK_W, 64, cipher block width; must be ≤ 8·DATA_W.
- KEY_W, 80, key width; must be ≤ 8·DATA_W.
- TIMEOUT, 1024, maximum RUN cycles before abort; must be ≥ 2.

Ports:
- clk  in  1  the single clock.
- iReset  in  1  reset, asynchronous and active-high.
- iChipselect_n  in  1  bus select, active low.
- iWrite_n  in  1  write strobe, active low.
- iRead_n  in  1  read strobe, active low.
- iAddress  in  5  word address.
- idat  in  DATA_W  write data.
- odat  out  DATA_W  registered read data.
- oIrq  out  1  level interrupt, equal to done & irq_en.
- oCoreReset_n  out  1  core reset, active low.
- oCoreLoad  out  1  one-cycle start pulse to the core.
- oCoreMode  out  1  0 = encrypt, 1 = decrypt.
- oCoreKey  out  KEY_W  key register.
- oCoreData  out  BLOCK_W  input block register.
- iCoreDone  in  1  core result valid.
- iCoreData  in  BLOCK_W  core result.

## Operation
- A write happens when iChipselect_n=0 and iWrite_n=0. A read happens when iChipselect_n=0, iWrite_n=1 and iRead_n=0. If both strobes are low, the write wins.
- Word counts: KW = ceil(KEY_W/DATA_W) and BW = ceil(BLOCK_W/DATA_W). Word 0 is always the least significant word.
- Address map:
  - 0x00 CTRL. Write: bit0 start (self-clearing), bit1 mode, bit2 irq_en. Read: {irq_en, mode, 0}.
  - 0x01 STATUS. Read: bit0 busy, bit1 done, bit2 err. Write: writing 1 to bit1 clears done; writing 1 to bit2 clears err.
  - 0x08+i KEY word i, for i < KW. Read/write.
  - 0x10+i DIN word i, for i < BW. Read/write.
  - 0x18+i DOUT word i, for i < BW. Read-only.
- Unmapped addresses: reads return 0; writes are ignored. Bits of a partial top word beyond KEY_W or BLOCK_W are dropped on write and read back as 0.
- FSM states:
  - IDLE. A CTRL write with bit0=1 loads mode, clears done and goes to LOAD.
  - LOAD. oCoreLoad=1 for exactly one cycle. The watchdog counter is cleared. Next state is RUN.
  - RUN. The counter increments every cycle.
    - If iCoreDone=1: capture iCoreData into DOUT, set done, go to IDLE.
    - Otherwise, if the counter reaches TIMEOUT-1: set err, go to ABORT.
  - ABORT. oCoreReset_n=0 for one cycle, then IDLE. done stays 0 and DOUT is unchanged.
- busy = (state != IDLE).
- While busy, writes to KEY, DIN or CTRL are ignored and set err. STATUS clear-writes are always honoured.
- Simultaneous events:
  - iCoreDone in the same cycle as timeout expiry: done wins, err is not set.
  - A STATUS write clearing done in the cycle done is being set: the set wins.
  - A start write while done=1 is legal and clears done.
- Reset mid-operation: every register returns to its reset value and the FSM goes to IDLE. Any in-flight result is lost.

## Timing
- Reset values:
  - odat=0, oIrq=0, oCoreLoad=0, oCoreMode=0.
  - oCoreKey=0, oCoreData=0, DOUT=0.
  - busy=done=err=irq_en=0.
  - oCoreReset_n=0 while iReset=1 and 1 from the first edge after release.
- Register writes take effect at the sampling edge and are visible on the core ports from the next cycle.
- Start write sampled at edge T: oCoreLoad=1 and busy=1 during cycle T+1; RUN from T+2.
- iCoreDone sampled high at edge R: DOUT, done=1, busy=0 and oIrq (if irq_en) are all visible after R.
- Read sampled at edge T: odat is valid after T and holds until the next read. On a write, odat is set to 0.
- Start-to-result latency = core latency + 2 cycles.
- Timeout: busy for at most TIMEOUT+2 cycles after the start edge.

## Test plan
- Encrypt flow with KEY_W=80, BLOCK_W=64 and a behavioural core model that asserts done 32 cycles after load.
  - Stimulus: write KEY words {0,0,0} and DIN {0,0}, then write CTRL=0x5.
  - Response: a single oCoreLoad pulse; busy for 34 cycles; DOUT = 0x5579C1387B228445 (PRESENT-80 zero-key, zero-plaintext vector); oIrq=1.
  - Writing STATUS=0x2 drops oIrq the next cycle.
- Partial word: write 0xFFFFFFFF to KEY word 2 → reads back 0x0000FFFF, and oCoreKey[79:64]=0xFFFF.
- Busy protection: while busy, write DIN word 0 = 0xDEADBEEF → DIN unchanged, STATUS reads 0x5, and the result is still correct.
- Watchdog: TIMEOUT=16 with a core that never asserts done.
  - Response: err=1 and busy=0 at start+18 cycles; oCoreReset_n low for exactly one cycle; done=0.
  - Then iCoreDone raised at the expiry edge → done=1, err=0.
- Reset mid-RUN: assert iReset 5 cycles after start → all outputs and registers read 0 immediately. A fresh run after release matches the first scenario.
- Strobe collisions: iWrite_n=0 and iRead_n=0 together on 0x08 → a write occurs and odat=0. Reads of 0x03 and 0x1F return 0.
